// File: rtl/sign_mag_acc.sv
// Sign-magnitude accumulator: sums a programmed number of (N+1)-bit sign-magnitude
// samples into an (M+1)-bit sign-magnitude total with a sticky saturation flag (M >= N).
module sign_mag_acc #(
  parameter int N  = 4,
  parameter int M  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  input  logic [N:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M:0]    out_data,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          acc_sign;
  logic [M-1:0]  acc_mag;
  logic [CW-1:0] cnt;
  logic          ovf_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;

  logic          in_sign;
  logic [M-1:0]  in_mag;
  logic          xfer;
  logic [M+1:0]  step;

  // Clamp an (M+1)-bit magnitude sum to the largest M-bit magnitude.
  function automatic logic [M-1:0] sat_mag(input logic [M:0] sum);
    return sum[M] ? {M{1'b1}} : sum[M-1:0];
  endfunction

  // One accumulation step; result packed as {saturated, sign, magnitude}.
  function automatic logic [M+1:0] sm_add(input logic         a_s,
                                          input logic [M-1:0] a_m,
                                          input logic         b_s,
                                          input logic [M-1:0] b_m);
    logic [M:0]   sum;
    logic         s;
    logic [M-1:0] m;
    logic         sat;
    sum = '0;
    sat = 1'b0;
    if (a_s == b_s) begin
      sum = {1'b0, a_m} + {1'b0, b_m};
      m   = sat_mag(sum);
      sat = sum[M];
      s   = a_s;
    end else if (a_m >= b_m) begin
      m = a_m - b_m;
      s = a_s;
    end else begin
      m = b_m - a_m;
      s = b_s;
    end
    // A zero magnitude is always reported as +0.
    if (m == '0) s = 1'b0;
    return {sat, s, m};
  endfunction

  always_comb begin
    in_mag          = '0;
    in_mag[N-1:0]   = in_data[N-1:0];
    // -0 on the input is folded to +0 before combining.
    in_sign         = in_data[N] & (|in_data[N-1:0]);
    xfer            = (state == ACC) && in_valid && in_ready_r;
    step            = sm_add(acc_sign, acc_mag, in_sign, in_mag);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      acc_sign    <= 1'b0;
      acc_mag     <= '0;
      cnt         <= '0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_sign <= 1'b0;
            acc_mag  <= '0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b1;
            if (len != '0) begin
              cnt        <= len;
              in_ready_r <= 1'b1;
              state      <= ACC;
            end else begin
              out_valid_r <= 1'b1;
              state       <= DONE;
            end
          end
        end
        ACC: begin
          if (xfer) begin
            acc_sign <= step[M];
            acc_mag  <= step[M-1:0];
            if (step[M+1]) ovf_r <= 1'b1;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = {acc_sign, acc_mag};
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule
